// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit.
//   wb_ix_inf_t     : register-file write port toward instruction issue
//   wb_src_e        : which EXE unit won writeback this cycle
//   exe_wb_result_t : normalised per-unit result presented to the selector
package writeback_unit_pkg;

  localparam int unsigned REG_WIDTH = 5;

  typedef struct packed {
    logic                 wr_en;
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          wr_data;
  } wb_ix_inf_t;

  typedef enum logic [2:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LSD,
    WB_SRC_MUL,
    WB_SRC_DIV
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          data;
  } exe_wb_result_t;

endpackage

// File: rtl/writeback_unit_if.sv
// EXE-to-writeback result bus. The EXE side (master) drives every signal;
// the writeback unit (slave) only samples. Signal names match the legacy
// flat ports of writeback_unit.
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic                 alu_valid;
  logic                 alu_wr_en;
  logic [REG_WIDTH-1:0] alu_rd;
  logic [31:0]          alu_data;
  logic                 alu_branch_taken;
  logic [31:0]          alu_branch_target;

  logic                 lsd_valid;
  logic                 lsd_wr_en;
  logic [REG_WIDTH-1:0] lsd_rd;
  logic [31:0]          lsd_data;
  logic                 lsd_replay;
  logic [31:0]          lsd_pc;

  logic                 mul_valid;
  logic [REG_WIDTH-1:0] mul_rd;
  logic [31:0]          mul_data;

  logic                 div_valid;
  logic [REG_WIDTH-1:0] div_rd;
  logic [31:0]          div_data;

  modport master (
    output alu_valid, alu_wr_en, alu_rd, alu_data, alu_branch_taken, alu_branch_target,
    output lsd_valid, lsd_wr_en, lsd_rd, lsd_data, lsd_replay, lsd_pc,
    output mul_valid, mul_rd, mul_data,
    output div_valid, div_rd, div_data
  );

  modport slave (
    input alu_valid, alu_wr_en, alu_rd, alu_data, alu_branch_taken, alu_branch_target,
    input lsd_valid, lsd_wr_en, lsd_rd, lsd_data, lsd_replay, lsd_pc,
    input mul_valid, mul_rd, mul_data,
    input div_valid, div_rd, div_data
  );

endinterface

// File: rtl/wb_priority_select.sv
// Combinational writeback arbiter.
//   *_res      : per-unit results
//   squash     : drop ALU/LSD results (wrong-path window after a redirect)
//   win_res    : winning result ('0 when nothing wins)
//   win_src    : winning unit
//   win_onehot : {div, mul, lsd, alu}
//   conflict   : more than one live result this cycle
module wb_priority_select
  import writeback_unit_pkg::*;
(
  input  exe_wb_result_t alu_res,
  input  exe_wb_result_t lsd_res,
  input  exe_wb_result_t mul_res,
  input  exe_wb_result_t div_res,
  input  logic           squash,
  output exe_wb_result_t win_res,
  output wb_src_e        win_src,
  output logic [3:0]     win_onehot,
  output logic           conflict
);

  logic [3:0] live;

  always_comb begin
    live       = {div_res.valid, mul_res.valid,
                  lsd_res.valid & ~squash, alu_res.valid & ~squash};
    win_res    = '0;
    win_src    = WB_SRC_NONE;
    win_onehot = '0;
    if (live[3]) begin
      win_res = div_res; win_src = WB_SRC_DIV; win_onehot = 4'b1000;
    end else if (live[2]) begin
      win_res = mul_res; win_src = WB_SRC_MUL; win_onehot = 4'b0100;
    end else if (live[1]) begin
      win_res = lsd_res; win_src = WB_SRC_LSD; win_onehot = 4'b0010;
    end else if (live[0]) begin
      win_res = alu_res; win_src = WB_SRC_ALU; win_onehot = 4'b0001;
    end
    // Clearing the lowest set bit leaves something only if two or more were set.
    conflict = |(live & (live - 4'd1));
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates EXE results onto the single register-file
// write port, raises redirects for taken branches and D$-miss replays,
// counts retired instructions and flags writeback collisions.
//   clk, rst         : clock, synchronous active-low reset
//   exe              : EXE result bus (slave side)
//   wb_ix_inf        : registered register-file write {wr_en, rd, wr_data}
//   wb_do_branch     : one-cycle redirect pulse, wb_branch_target its PC
//   wb_retire_count  : wrapping retired-instruction counter
//   wb_conflict_err  : sticky collision flag
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned RETIRE_CNT_WIDTH = 64,
  parameter bit          REPORT_RD0       = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  writeback_unit_if.slave             exe,
  output wb_ix_inf_t                  wb_ix_inf,
  output logic                        wb_do_branch,
  output logic [31:0]                 wb_branch_target,
  output logic [RETIRE_CNT_WIDTH-1:0] wb_retire_count,
  output logic                        wb_conflict_err
);

  exe_wb_result_t alu_res, lsd_res, mul_res, div_res, win_res;
  wb_src_e        win_src;
  logic [3:0]     win_onehot;
  logic           conflict;

  wb_ix_inf_t                  ix_d, ix_q;
  logic                        branch_d, branch_q;
  logic [31:0]                 target_d, target_q;
  logic [RETIRE_CNT_WIDTH-1:0] count_d, count_q;
  logic                        err_d, err_q;

  always_comb begin
    alu_res = '{valid: exe.alu_valid, wr_en: exe.alu_wr_en, rd: exe.alu_rd, data: exe.alu_data};
    // A replayed load never writes; the refetched instruction will.
    lsd_res = '{valid: exe.lsd_valid, wr_en: exe.lsd_wr_en & ~exe.lsd_replay,
                rd: exe.lsd_rd, data: exe.lsd_data};
    mul_res = '{valid: exe.mul_valid, wr_en: 1'b1, rd: exe.mul_rd, data: exe.mul_data};
    div_res = '{valid: exe.div_valid, wr_en: 1'b1, rd: exe.div_rd, data: exe.div_data};
  end

  wb_priority_select u_select (
    .alu_res    (alu_res),
    .lsd_res    (lsd_res),
    .mul_res    (mul_res),
    .div_res    (div_res),
    .squash     (branch_q),
    .win_res    (win_res),
    .win_src    (win_src),
    .win_onehot (win_onehot),
    .conflict   (conflict)
  );

  always_comb begin
    ix_d     = '{wr_en: 1'b0, rd: ix_q.rd, wr_data: ix_q.wr_data};
    branch_d = 1'b0;
    target_d = target_q;
    count_d  = count_q;
    err_d    = err_q | conflict;
    if (win_res.valid) begin
      ix_d.wr_en   = win_res.wr_en & (REPORT_RD0 | (win_res.rd != '0));
      ix_d.rd      = win_res.rd;
      ix_d.wr_data = win_res.data;
      if (win_src == WB_SRC_LSD && exe.lsd_replay) begin
        branch_d = 1'b1;
        target_d = exe.lsd_pc;
      end else begin
        count_d = count_q + RETIRE_CNT_WIDTH'(1);
        if (win_src == WB_SRC_ALU && exe.alu_branch_taken) begin
          branch_d = 1'b1;
          target_d = exe.alu_branch_target;
        end
      end
    end
  end

  always_comb begin
    assert ($onehot0(win_onehot) && (win_res.valid == (win_onehot != '0)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ix_q     <= '0;
      branch_q <= 1'b0;
      target_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ix_q     <= ix_d;
      branch_q <= branch_d;
      target_q <= target_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign wb_ix_inf        = ix_q;
  assign wb_do_branch     = branch_q;
  assign wb_branch_target = target_q;
  assign wb_retire_count  = count_q;
  assign wb_conflict_err  = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a reference model pushes expected
// outputs when stimulus is driven; they are popped one cycle later and
// compared. A second instance (4-bit counter, rd0 reported) covers wrap
// and REPORT_RD0=1.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_unit_if exe_if ();

  wb_ix_inf_t  wb_ix_inf, sm_ix;
  logic        wb_do_branch, sm_br, wb_conflict_err, sm_err;
  logic [31:0] wb_branch_target, sm_tgt;
  logic [63:0] wb_retire_count;
  logic [3:0]  sm_cnt;

  writeback_unit #(.RETIRE_CNT_WIDTH(64), .REPORT_RD0(1'b0)) dut (
    .clk(clk), .rst(rst), .exe(exe_if),
    .wb_ix_inf(wb_ix_inf), .wb_do_branch(wb_do_branch),
    .wb_branch_target(wb_branch_target), .wb_retire_count(wb_retire_count),
    .wb_conflict_err(wb_conflict_err)
  );

  writeback_unit #(.RETIRE_CNT_WIDTH(4), .REPORT_RD0(1'b1)) dut_small (
    .clk(clk), .rst(rst), .exe(exe_if),
    .wb_ix_inf(sm_ix), .wb_do_branch(sm_br),
    .wb_branch_target(sm_tgt), .wb_retire_count(sm_cnt),
    .wb_conflict_err(sm_err)
  );

  typedef struct packed {
    logic alu_valid; logic alu_wr_en; logic [4:0] alu_rd; logic [31:0] alu_data;
    logic alu_taken; logic [31:0] alu_tgt;
    logic lsd_valid; logic lsd_wr_en; logic [4:0] lsd_rd; logic [31:0] lsd_data;
    logic lsd_replay; logic [31:0] lsd_pc;
    logic mul_valid; logic [4:0] mul_rd; logic [31:0] mul_data;
    logic div_valid; logic [4:0] div_rd; logic [31:0] div_data;
  } stim_t;

  typedef struct packed {
    logic wr_en; logic [4:0] rd; logic [31:0] data;
    logic br; logic [31:0] tgt; logic [63:0] cnt; logic err;
  } exp_t;

  stim_t s;
  exp_t  sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model state
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_tgt;
  logic [63:0] m_cnt;
  logic        m_err, m_br, prev_br;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    m_rd = '0; m_data = '0; m_tgt = '0; m_cnt = '0; m_err = 1'b0; m_br = 1'b0;
    prev_br = 1'b0;
  endtask

  task automatic apply();
    exe_if.alu_valid = s.alu_valid; exe_if.alu_wr_en = s.alu_wr_en;
    exe_if.alu_rd = s.alu_rd; exe_if.alu_data = s.alu_data;
    exe_if.alu_branch_taken = s.alu_taken; exe_if.alu_branch_target = s.alu_tgt;
    exe_if.lsd_valid = s.lsd_valid; exe_if.lsd_wr_en = s.lsd_wr_en;
    exe_if.lsd_rd = s.lsd_rd; exe_if.lsd_data = s.lsd_data;
    exe_if.lsd_replay = s.lsd_replay; exe_if.lsd_pc = s.lsd_pc;
    exe_if.mul_valid = s.mul_valid; exe_if.mul_rd = s.mul_rd; exe_if.mul_data = s.mul_data;
    exe_if.div_valid = s.div_valid; exe_if.div_rd = s.div_rd; exe_if.div_data = s.div_data;
  endtask

  // Expected outputs after the next edge, from the current stimulus.
  task automatic model(output exp_t e);
    logic alu_ok, lsd_ok, winner, wr;
    int   n;
    alu_ok = s.alu_valid && !m_br;
    lsd_ok = s.lsd_valid && !m_br;
    n = int'(s.div_valid) + int'(s.mul_valid) + int'(lsd_ok) + int'(alu_ok);
    if (n > 1) m_err = 1'b1;
    winner = (n > 0);
    wr = 1'b0;
    m_br = 1'b0;
    if (s.div_valid) begin
      m_rd = s.div_rd; m_data = s.div_data; wr = 1'b1; m_cnt++;
    end else if (s.mul_valid) begin
      m_rd = s.mul_rd; m_data = s.mul_data; wr = 1'b1; m_cnt++;
    end else if (lsd_ok) begin
      m_rd = s.lsd_rd; m_data = s.lsd_data;
      if (s.lsd_replay) begin m_br = 1'b1; m_tgt = s.lsd_pc; end
      else begin wr = s.lsd_wr_en; m_cnt++; end
    end else if (alu_ok) begin
      m_rd = s.alu_rd; m_data = s.alu_data; wr = s.alu_wr_en; m_cnt++;
      if (s.alu_taken) begin m_br = 1'b1; m_tgt = s.alu_tgt; end
    end
    if (winner && m_rd == 5'd0) wr = 1'b0;
    e = '{wr_en: wr, rd: m_rd, data: m_data, br: m_br, tgt: m_tgt, cnt: m_cnt, err: m_err};
  endtask

  task automatic cycle();
    exp_t e;
    apply();
    model(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("wr_en",   wb_ix_inf.wr_en,   e.wr_en);
    check_eq("rd",      wb_ix_inf.rd,      e.rd);
    check_eq("wr_data", wb_ix_inf.wr_data, e.data);
    check_eq("do_branch", wb_do_branch,    e.br);
    check_eq("target",  wb_branch_target,  e.tgt);
    check_eq("retire",  wb_retire_count,   e.cnt);
    check_eq("conflict_err", wb_conflict_err, e.err);
    check_eq("no_b2b_branch", prev_br & wb_do_branch, 1'b0);
    prev_br = wb_do_branch;
  endtask

  initial begin
    // reset with every valid asserted
    rst = 1'b0;
    s = '1;
    apply();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wr_en", wb_ix_inf, '0);
    check_eq("rst_branch", wb_do_branch, 1'b0);
    check_eq("rst_target", wb_branch_target, '0);
    check_eq("rst_count", wb_retire_count, '0);
    check_eq("rst_err", wb_conflict_err, 1'b0);
    check_eq("rst_small_count", sm_cnt, '0);
    model_reset();
    rst = 1'b1;

    // MUL write
    s = '0; s.mul_valid = 1'b1; s.mul_rd = 5'd5; s.mul_data = 32'hDEADBEEF;
    cycle();
    check_eq("mul_count_1", wb_retire_count, 64'd1);

    // taken branch, then squashed ALU alongside an older DIV
    s = '0; s.alu_valid = 1'b1; s.alu_taken = 1'b1; s.alu_tgt = 32'h100;
    cycle();
    check_eq("branch_tgt_100", wb_branch_target, 64'h100);
    s = '0; s.alu_valid = 1'b1; s.alu_wr_en = 1'b1; s.alu_rd = 5'd7; s.alu_data = 32'h77;
    s.div_valid = 1'b1; s.div_rd = 5'd3; s.div_data = 32'h33;
    cycle();
    check_eq("div_commit_rd", wb_ix_inf.rd, 64'd3);

    // LSD replay
    s = '0; s.lsd_valid = 1'b1; s.lsd_replay = 1'b1; s.lsd_wr_en = 1'b1;
    s.lsd_rd = 5'd9; s.lsd_pc = 32'h2004; s.lsd_data = 32'h99;
    cycle();
    check_eq("replay_tgt", wb_branch_target, 64'h2004);
    s = '0;
    cycle();

    // collision: MUL beats ALU, error sticks
    s = '0; s.mul_valid = 1'b1; s.mul_rd = 5'd4; s.mul_data = 32'd1;
    s.alu_valid = 1'b1; s.alu_wr_en = 1'b1; s.alu_rd = 5'd6; s.alu_data = 32'd2;
    cycle();
    s = '0;
    repeat (10) cycle();
    check_eq("err_sticky", wb_conflict_err, 1'b1);

    // rd0 write: suppressed on main instance, reported on the small one
    s = '0; s.alu_valid = 1'b1; s.alu_wr_en = 1'b1; s.alu_rd = 5'd0; s.alu_data = 32'h55;
    cycle();
    check_eq("rd0_small_wr", sm_ix.wr_en, 1'b1);

    // random single-issue traffic
    for (int i = 0; i < 40; i++) begin
      s = '0;
      case ($urandom_range(0, 4))
        0: begin
          s.alu_valid = 1'b1; s.alu_wr_en = 1'($urandom); s.alu_rd = 5'($urandom);
          s.alu_data = $urandom; s.alu_taken = ($urandom_range(0, 3) == 0); s.alu_tgt = $urandom;
        end
        1: begin
          s.lsd_valid = 1'b1; s.lsd_wr_en = 1'($urandom); s.lsd_rd = 5'($urandom);
          s.lsd_data = $urandom; s.lsd_replay = ($urandom_range(0, 3) == 0); s.lsd_pc = $urandom;
        end
        2: begin s.mul_valid = 1'b1; s.mul_rd = 5'($urandom); s.mul_data = $urandom; end
        3: begin s.div_valid = 1'b1; s.div_rd = 5'($urandom); s.div_data = $urandom; end
        default: ;
      endcase
      cycle();
    end

    // reset mid-operation discards the in-flight MUL
    rst = 1'b0;
    s = '0; s.mul_valid = 1'b1; s.mul_rd = 5'd12; s.mul_data = 32'h1234;
    apply();
    @(posedge clk);
    #1;
    check_eq("midrst_ix", wb_ix_inf, '0);
    check_eq("midrst_count", wb_retire_count, '0);
    check_eq("midrst_err", wb_conflict_err, 1'b0);
    model_reset();
    rst = 1'b1;

    // counter wrap on the 4-bit instance
    s = '0; s.alu_valid = 1'b1; s.alu_rd = 5'd1;
    repeat (15) cycle();
    check_eq("wrap_pre", sm_cnt, 4'hF);
    cycle();
    check_eq("wrap_zero", sm_cnt, 4'h0);
    check_eq("wrap_main_16", wb_retire_count, 64'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Terminating end of the EXE pipes. Collects results from the ALU, LSD, MUL and DIV units and drives the single register-file write port back into instruction issue.
- Generates the pipeline redirect (`wb_do_branch` plus target) for taken branches/jumps and for LSD replays (D$ miss).
- Maintains a retired-instruction counter and a sticky writeback-collision error flag for verification.

Parameters:
- RETIRE_CNT_WIDTH, 64, width of the retired-instruction counter; it wraps modulo 2^RETIRE_CNT_WIDTH.
- REPORT_RD0, 0, if 1 then writes to rd==0 are still presented on the write port; if 0 they are suppressed.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result valid this cycle
- alu_wr_en  in  1  ALU instruction writes rd
- alu_rd  in  REG_WIDTH  ALU destination register
- alu_data  in  32  ALU result, or pc_inc for jumps
- alu_branch_taken  in  1  taken branch or jump
- alu_branch_target  in  32  redirect PC
- lsd_valid  in  1  LSD result valid
- lsd_wr_en  in  1  load writes rd
- lsd_rd  in  REG_WIDTH  load destination register
- lsd_data  in  32  load data
- lsd_replay  in  1  D$ miss; instruction must be re-fetched
- lsd_pc  in  32  PC of the replayed LSU instruction
- mul_valid  in  1  MUL result valid
- mul_rd  in  REG_WIDTH  MUL destination register
- mul_data  in  32  MUL result
- div_valid  in  1  DIV result valid
- div_rd  in  REG_WIDTH  DIV destination register
- div_data  in  32  DIV result
- wb_ix_inf  out  $bits(wb_ix_inf_t)  register-file write {wr_en, rd, wr_data}
- wb_do_branch  out  1  one-cycle redirect pulse
- wb_branch_target  out  32  redirect PC, valid when wb_do_branch is 1
- wb_retire_count  out  RETIRE_CNT_WIDTH  retired-instruction count
- wb_conflict_err  out  1  sticky flag: more than one unit presented a result in the same cycle

Behaviour:
- All outputs are registered. Latency is 1 cycle from input valid to output.
- Reset (rst==0 at posedge) values:
  - `wb_ix_inf.wr_en` = 0, `rd` = 0, `wr_data` = 0
  - `wb_do_branch` = 0, `wb_branch_target` = 0
  - `wb_retire_count` = 0, `wb_conflict_err` = 0
- Reset mid-operation discards every in-flight input; nothing is written on the reset cycle.
- Squash window:
  - While `wb_do_branch` is 1, `alu_valid` and `lsd_valid` are ignored. These results belong to younger, wrong-path instructions.
  - `mul_valid` and `div_valid` are never squashed; these results are older and must commit.
- Selection among non-squashed valids uses fixed priority DIV > MUL > LSD > ALU.
  - Issue guarantees at most one valid per cycle.
  - If two or more non-squashed valids coincide, only the winner is processed, the losers are dropped, and `wb_conflict_err` is set to 1 and held until reset.
- Write port, next cycle:
  - `wr_en` = winner's write enable: 1 for MUL/DIV, `alu_wr_en` or `lsd_wr_en` otherwise.
  - For LSD, `wr_en` is forced to 0 when `lsd_replay` is 1.
  - `rd` and `wr_data` come from the winner.
  - With REPORT_RD0=0, `wr_en` is forced to 0 when rd==0.
  - With no winner, `wr_en` = 0 and `rd`/`wr_data` hold their previous values.
- Redirect, next cycle:
  - `wb_do_branch` = 1 if the winner is the ALU with `alu_branch_taken`; `wb_branch_target` = `alu_branch_target`.
  - `wb_do_branch` = 1 if the winner is the LSD with `lsd_replay`; `wb_branch_target` = `lsd_pc`.
  - Otherwise `wb_do_branch` = 0 and `wb_branch_target` holds.
  - `wb_do_branch` is never high on two consecutive cycles: the squash window blocks the only redirect sources.
- Retirement: `wb_retire_count` increments by 1 on every cycle with a winner, except an LSD winner with `lsd_replay`=1. A register write is not required to retire; branches and stores retire too. The counter wraps from all-ones to 0.
- No backpressure toward EXE units. Every input is consumed or dropped in its valid cycle.

Decomposition:
- defines package:
  - `wb_ix_inf_t` (existing)
  - new enum `wb_src_e` {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_LSD, WB_SRC_MUL, WB_SRC_DIV}
  - new struct `exe_wb_result_t` {valid, wr_en, rd, data}
- Sub-module: `wb_priority_select` (combinational winner select, one-hot, and conflict detect). The counter and output registers stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all valids high -> all outputs 0; `wb_retire_count`=0.
- MUL write: mul_valid=1, mul_rd=5, mul_data=0xDEADBEEF -> next cycle wr_en=1, rd=5, wr_data=0xDEADBEEF, retire_count=1, wb_do_branch=0.
- Taken branch with squash:
  - Cycle 0: alu_valid=1, alu_branch_taken=1, alu_branch_target=0x100, alu_wr_en=0 -> cycle 1: wb_do_branch=1, target=0x100.
  - Cycle 1: alu_valid=1, alu_rd=7 -> dropped (wr_en=0 in cycle 2, count unchanged).
  - Cycle 1: div_valid=1, div_rd=3 -> committed in cycle 2.
- LSD replay: lsd_valid=1, lsd_replay=1, lsd_wr_en=1, lsd_rd=9, lsd_pc=0x2004 -> wb_do_branch=1, target=0x2004, wr_en=0, retire_count unchanged.
- Collision: mul_valid=1 (rd=4, data=1) and alu_valid=1 (rd=6, data=2) in the same cycle -> wr_en=1, rd=4, wr_data=1; wb_conflict_err=1, still 1 after 10 idle cycles.
- rd0 and wrap:
  - alu_valid=1, alu_rd=0, alu_wr_en=1 with REPORT_RD0=0 -> wr_en=0, count+1.
  - Preload the counter to all-ones (RETIRE_CNT_WIDTH=4 build) and retire one -> count=0.
